ir_fetch_seq: RTL and testbench

Fetch sequencer for the 16-bit instruction register, which is loaded from an 8-bit memory bus one half at a time.
- Issues byte reads to memory and steers each returned byte into the correct IR half (l_h select).
- Strobes the IR load and advances the PC once per byte.
- Presents the completed instruction to decode with a valid/ready handshake.
- Sits between the memory/PC datapath and the decode/execute control.

---
 rtl/ir_fetch_pkg.sv | 21 ++
 rtl/fetch_tmo_cnt.sv | 30 +++
 rtl/ir_fetch_seq.sv | 121 ++++++++++++
 tb/tb_ir_fetch_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ir_fetch_pkg.sv
// Shared types and constants for the IR fetch sequencer.
// IR function selects and half selects match the IR datapath encoding.
package ir_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    REQ_B,
    HOLD,
    CLEAR,
    ERR
  } state_e;

  localparam logic [1:0] FS_HOLD  = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b10;
  localparam logic [1:0] FS_CLEAR = 2'b11;

  localparam logic SEL_HI = 1'b1;
  localparam logic SEL_LO = 1'b0;

endpackage

// File: rtl/fetch_tmo_cnt.sv
// Saturating memory-wait counter for the IR fetch sequencer.
// expired flags the cycle whose miss brings the count to its maximum.
module fetch_tmo_cnt #(
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] MAX = '1;
  localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + ONE;
    end
  end

  assign expired = (cnt == MAX - ONE);

endmodule

// File: rtl/ir_fetch_seq.sv
// Fetch sequencer: two byte reads into the 16-bit IR, then a
// valid/ready hand-off to decode. flush aborts and clears the IR.
module ir_fetch_seq
  import ir_fetch_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1,
  parameter int TMO_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       flush,
  output logic       mem_re,
  input  logic       mem_ack,
  output logic       pc_inc,
  output logic       ir_e,
  output logic [1:0] ir_funsel,
  output logic       ir_l_h,
  output logic       ins_valid,
  input  logic       ins_ready,
  output logic       fetch_err
);

  localparam logic SEL_A = HI_FIRST ? SEL_HI : SEL_LO;
  localparam logic SEL_B = HI_FIRST ? SEL_LO : SEL_HI;

  state_e state_q, state_d;
  logic   err_q;
  logic   err_set;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   expired;

  fetch_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (state_q == CLEAR) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_re    = 1'b0;
    pc_inc    = 1'b0;
    ir_e      = 1'b0;
    ir_funsel = FS_HOLD;
    ir_l_h    = 1'b0;
    ins_valid = 1'b0;
    cnt_clr   = 1'b1;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = REQ_A;
      end
      REQ_A, REQ_B: begin
        mem_re = 1'b1;
        ir_l_h = (state_q == REQ_A) ? SEL_A : SEL_B;
        if (mem_ack) begin
          ir_e      = 1'b1;
          ir_funsel = FS_LOAD;
          pc_inc    = 1'b1;
          state_d   = (state_q == REQ_A) ? REQ_B : HOLD;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
          if (expired) begin
            err_set = 1'b1;
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        ins_valid = 1'b1;
        if (ins_ready) state_d = run ? REQ_A : IDLE;
      end
      CLEAR: begin
        ir_e      = 1'b1;
        ir_funsel = FS_CLEAR;
        state_d   = IDLE;
      end
      ERR: begin
      end
      default: state_d = IDLE;
    endcase

    // A held flush re-enters CLEAR, so CLEAR keeps its own strobe.
    if (flush) begin
      state_d = CLEAR;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
      err_set = 1'b0;
      if (state_q != CLEAR) begin
        mem_re    = 1'b0;
        pc_inc    = 1'b0;
        ir_e      = 1'b0;
        ir_funsel = FS_HOLD;
        ins_valid = 1'b0;
      end
    end
  end

  assign fetch_err = err_q;

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Directed bench for ir_fetch_seq: big-endian main instance plus a
// little-endian instance with a small IR model.
module tb_ir_fetch_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic run = 1'b0, flush = 1'b0, mem_ack = 1'b0, ins_ready = 1'b0;
  logic mem_re, pc_inc, ir_e, ir_l_h, ins_valid, fetch_err;
  logic [1:0] ir_funsel;

  logic run2 = 1'b0, ack2 = 1'b0, rdy2 = 1'b0;
  logic mem_re2, pc_inc2, ir_e2, ir_l_h2, ins_valid2, fetch_err2;
  logic [1:0] funsel2;
  logic [7:0] byte2 = 8'h00;
  logic [15:0] ir2;

  int checks = 0;
  int failures = 0;
  int pulses;

  logic [7:0] o;
  assign o = {mem_re, ir_l_h, ir_e, ir_funsel, pc_inc, ins_valid, fetch_err};

  always #5 clk = ~clk;

  ir_fetch_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .flush     (flush),
    .mem_re    (mem_re),
    .mem_ack   (mem_ack),
    .pc_inc    (pc_inc),
    .ir_e      (ir_e),
    .ir_funsel (ir_funsel),
    .ir_l_h    (ir_l_h),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .fetch_err (fetch_err)
  );

  ir_fetch_seq #(.HI_FIRST(1'b0), .TMO_W(4)) u_le (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run2),
    .flush     (1'b0),
    .mem_re    (mem_re2),
    .mem_ack   (ack2),
    .pc_inc    (pc_inc2),
    .ir_e      (ir_e2),
    .ir_funsel (funsel2),
    .ir_l_h    (ir_l_h2),
    .ins_valid (ins_valid2),
    .ins_ready (rdy2),
    .fetch_err (fetch_err2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir2 <= 16'h0000;
    end else if (ir_e2 && funsel2 == 2'b10) begin
      if (ir_l_h2) ir2[15:8] <= byte2;
      else         ir2[7:0]  <= byte2;
    end else if (ir_e2 && funsel2 == 2'b11) begin
      ir2 <= 16'h0000;
    end
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic a,
                     input logic y);
    @(negedge clk);
    run = r; flush = f; mem_ack = a; ins_ready = y;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [3];
    pat[0] = 8'hF4; pat[1] = 8'hB4; pat[2] = 8'h02;

    #12;
    check("reset", {8'h00, o}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(0, 0, 0, 0);
    check("idle_norun", {8'h00, o}, 16'h0000);
    cyc(1, 0, 1, 1);
    check("idle_run", {8'h00, o}, 16'h0000);

    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 0, 1, 1);
      check($sformatf("stream%0d", i), {8'h00, o}, {8'h00, pat[i % 3]});
      if (pc_inc) pulses++;
    end
    check("pc_pulses", 16'(pulses), 16'd20);

    cyc(1, 0, 1, 1);
    check("wait_reqa", {8'h00, o}, 16'h00F4);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("wait_b%0d", i), {8'h00, o}, 16'h0080);
    end
    cyc(1, 0, 1, 0);
    check("wait_ack", {8'h00, o}, 16'h00B4);

    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("hold%0d", i), {8'h00, o}, 16'h0002);
    end
    cyc(0, 0, 0, 1);
    check("hold_hs", {8'h00, o}, 16'h0002);
    cyc(0, 0, 0, 0);
    check("hold_idle", {8'h00, o}, 16'h0000);

    cyc(1, 0, 0, 0);
    check("tmo_idle", {8'h00, o}, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("tmo_wait%0d", i), {8'h00, o}, 16'h00C0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("tmo_err%0d", i), {8'h00, o}, 16'h0001);
    end
    cyc(0, 1, 0, 0);
    check("err_flush", {8'h00, o}, 16'h0001);
    cyc(0, 0, 0, 0);
    check("err_clear", {8'h00, o}, 16'h0039);
    cyc(0, 0, 0, 0);
    check("err_idle", {8'h00, o}, 16'h0000);

    cyc(1, 0, 1, 1);
    check("fl_idle", {8'h00, o}, 16'h0000);
    cyc(1, 1, 1, 1);
    check("fl_kill", {8'h00, o & 8'hBF}, 16'h0000);
    cyc(1, 0, 1, 1);
    check("fl_clear", {8'h00, o}, 16'h0038);
    cyc(1, 0, 1, 1);
    check("fl_idle2", {8'h00, o}, 16'h0000);
    cyc(1, 0, 1, 1);
    check("fl_reqa", {8'h00, o}, 16'h00F4);
    cyc(1, 0, 1, 1);
    check("rst_reqb", {8'h00, o}, 16'h00B4);
    rst_n = 1'b0;
    #1;
    check("rst_async", {8'h00, o}, 16'h0000);

    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run2 = 1'b1; ack2 = 1'b1; rdy2 = 1'b0;
    @(negedge clk);
    byte2 = 8'h34;
    #1;
    check("le_first", {13'd0, ir_l_h2, ir_e2, pc_inc2}, 16'h0003);
    @(negedge clk);
    byte2 = 8'h12;
    #1;
    check("le_second", {13'd0, ir_l_h2, ir_e2, pc_inc2}, 16'h0007);
    @(negedge clk);
    #1;
    check("le_valid", {15'd0, ins_valid2}, 16'h0001);
    check("le_ir", ir2, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
